// File: rtl/mem_responder.sv
// Word-addressed memory slave for the cache-to-memory request interface.
// Each request is latched, held for WAIT_CYCLES wait states, acked for one cycle, then followed by one recovery cycle.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_cs_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ack_o,
    output logic        busy_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_ACK     = 2'd2;
    localparam logic [1:0] S_RECOVER = 2'd3;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_ack;
    logic                  r_busy;
    logic [DATA_W-1:0]     r_mem [DEPTH];

    logic [1:0]            w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_latch;
    logic                  w_mem_wr;
    logic                  w_mem_rd;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [DATA_W-ADDR_WIDTH-1:0] w_unused_addr;

    // Byte address to word index; low byte-lane bits and high bits alias.
    assign w_idx         = mem_addr_i[ADDR_WIDTH+1:2];
    assign w_unused_addr = {mem_addr_i[DATA_W-1:ADDR_WIDTH+2], mem_addr_i[1:0]};

    // Next-state and per-edge action decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_mem_wr    = 1'b0;
        w_mem_rd    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_cs_i) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!mem_cs_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_ACK;
                    w_mem_wr    = r_we;
                    w_mem_rd    = !r_we;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_ACK:     w_state_nxt = S_RECOVER;
            S_RECOVER: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Control, request latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= (w_state_nxt == S_ACK);
            r_busy  <= (w_state_nxt != S_IDLE);
            if (w_latch) begin
                r_addr  <= w_idx;
                r_we    <= mem_we_i;
                r_wdata <= mem_data_i;
            end
            if (w_mem_rd) begin
                r_rdata <= r_mem[r_addr];
            end
        end
    end

    // Storage array is not reset; a reset edge suppresses any pending write.
    always_ff @(posedge clk) begin
        if (!rst && w_mem_wr) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign mem_data_o = r_rdata;
    assign mem_ack_o  = r_ack;
    assign busy_o     = r_busy;

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory slave answering the cache-to-memory request interface (cs/we/addr/data/ack) driven by the cache management unit. Each request is accepted, delayed by a programmable number of wait states, completed with a single-cycle acknowledge, and followed by one recovery cycle. Line fill and write-back bursts are therefore served one word per handshake. The block sits below the cache in the lab SoC and stands in for main memory.

## Interface
- ADDR_WIDTH, 10, word-address bits; capacity is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 3, extra wait states per access; legal range 0..15; counter is 4 bits.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high; clock clk
- mem_cs_i  in  1  request valid; held high by the initiator until ack
- mem_we_i  in  1  1 = write, 0 = read
- mem_addr_i  in  32  byte address; bits [ADDR_WIDTH+1:2] index the array; bits [1:0] and bits above ADDR_WIDTH+1 are ignored, so the array aliases
- mem_data_i  in  32  write data
- mem_data_o  out  32  read data, registered; valid in the ack cycle and held until the next read ack
- mem_ack_o  out  1  one-cycle completion strobe
- busy_o  out  1  high in every state except IDLE

## Operation
- States: IDLE, WAIT, ACK, RECOVER. Encoding is free.
- Reset: state IDLE, mem_ack_o 0, mem_data_o 0, busy_o 0, counter 0, latches 0. Array contents are not reset.
- IDLE:
  - If cs_i=1 at the clock edge: latch addr index, we_i and data_i; load cnt←WAIT_CYCLES; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT, evaluated at each edge, in priority order:
  - cs_i=0: abort. Go to IDLE. No array write, no ack, mem_data_o unchanged.
  - cnt==0: go to ACK. At this same edge, a latched write updates array[addr]; a latched read loads mem_data_o←array[addr].
  - Otherwise cnt←cnt-1.
- ACK: mem_ack_o=1 for exactly this cycle. Go to RECOVER unconditionally. cs_i is ignored.
- RECOVER: mem_ack_o=0. cs_i is ignored. Go to IDLE. This gives the initiator one cycle to present the next word's address and data.
- Changes to addr_i, we_i or data_i after the IDLE edge have no effect on the current access, because all three are latched.
- The array is a single-port synchronous RAM. There is no read-during-write hazard, since only one access is in flight.
- rst has priority over everything. Reset in WAIT aborts the access with no write; reset in ACK drops mem_ack_o the following cycle.

## Timing
- Cycle c0 is the first cycle cs_i=1 with the block in IDLE.
  - WAIT occupies c1..c(WAIT_CYCLES+1).
  - mem_ack_o=1 in c(WAIT_CYCLES+2).
  - RECOVER is c(WAIT_CYCLES+3).
  - IDLE samples the next request in c(WAIT_CYCLES+4).
- Per-word period is WAIT_CYCLES+4 cycles. A 4-word burst is 4·(WAIT_CYCLES+4) cycles (28 at the default).
- Read data appears in the ack cycle, not earlier. mem_data_o holds through subsequent writes and aborts.
- Write is visible to a read request issued at or after the RECOVER cycle.
- busy_o rises in c1 and falls in c(WAIT_CYCLES+4).

## Test plan
- Reset check: assert rst for 2 cycles with cs_i=1 → mem_ack_o=0, mem_data_o=0, busy_o=0 throughout. Response starts only when cs_i is first sampled after rst falls.
- Single write/read, WAIT_CYCLES=3:
  - Write 0xDEADBEEF to 0x0000_0010 → ack exactly at c5, one cycle wide.
  - Read 0x0000_0010 → mem_data_o=0xDEADBEEF in its ack cycle.
- 4-word burst, default parameters: write 0x11111111..0x44444444 to 0x40, 0x44, 0x48, 0x4C, advancing address in the cycle after each ack → 4 acks, 7 cycles apart. A read burst returns the same values in order.
- Abort: read request, drop cs_i in c2 → no ack, back to IDLE at c3, mem_data_o unchanged. Same test with a write to 0x20 → a later read of 0x20 returns the old value.
- Reset mid-WAIT: write 0xCAFEF00D to 0x30, rst in c2 → no ack, location 0x30 unmodified.
- Edge parameters:
  - WAIT_CYCLES=0 → ack in c2, period 4 cycles.
  - Alias: ADDR_WIDTH=10, write to 0x1000 → a read of 0x0000 returns that value.
  - Misaligned: a read of 0x0000_0013 returns array[4].
